// File: rtl/tpu_sequencer.sv
// tpu_sequencer: job sequencer for the TinyTPU datapath.
// Walks the serial loader and the systolic PE array through one fixed job:
// clear -> serial load -> gap -> init -> stream -> compute -> capture -> done.
// Every output is a flop whose next value is decoded from the next state, so
// each strobe appears in exactly the cycle the job schedule names, and no input
// reaches an output combinationally.
module tpu_sequencer #(
  parameter int D_W  = 8,   // operand width; one operand takes D_W load cycles
  parameter int N    = 2,   // array dimension (N rows x N words, for X and Y)
  parameter int COMP = 5    // compute drain cycles after streaming; >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic load_en,
  output logic init,
  output logic pe_clr,
  output logic acc_capture,
  output logic sub_rst,
  output logic busy,
  output logic done
);

  // Number of load cycles: every bit of every operand of both matrices is
  // shifted in serially, X and Y in parallel.
  localparam int L = N * N * D_W;

  // One down-counter serves every timed state, so it is sized for the
  // longest dwell among LOAD, STREAM and COMPUTE.
  localparam int MAX_LS = (L > N + 1) ? L : N + 1;
  localparam int MAX_ALL = (MAX_LS > COMP) ? MAX_LS : COMP;
  localparam int CNT_W = $clog2(MAX_ALL + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LOAD_CNT   = cnt_t'(L);
  localparam cnt_t STREAM_CNT = cnt_t'(N + 1);
  localparam cnt_t COMP_CNT   = cnt_t'(COMP);
  localparam cnt_t ONE_CNT    = cnt_t'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_INIT,
    S_STREAM,
    S_COMPUTE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  logic load_en_q, load_en_d;
  logic init_q, init_d;
  logic pe_clr_q, pe_clr_d;
  logic acc_capture_q, acc_capture_d;
  logic sub_rst_q, sub_rst_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Dwell length loaded into the counter when a state is entered. The state
  // is left in the cycle the counter shows 1, so single-cycle states load 1.
  function automatic cnt_t entry_count(input state_t s);
    cnt_t c;
    case (s)
      S_IDLE:    c = '0;
      S_LOAD:    c = LOAD_CNT;
      S_STREAM:  c = STREAM_CNT;
      S_COMPUTE: c = COMP_CNT;
      default:   c = ONE_CNT;
    endcase
    return c;
  endfunction

  // Fixed job order once the current state's dwell has expired.
  function automatic state_t successor(input state_t s);
    state_t n;
    case (s)
      S_LOAD:    n = S_GAP;
      S_GAP:     n = S_INIT;
      S_INIT:    n = S_STREAM;
      S_STREAM:  n = S_COMPUTE;
      S_COMPUTE: n = S_CAPTURE;
      S_CAPTURE: n = S_DONE;
      default:   n = S_IDLE;
    endcase
    return n;
  endfunction

  // Next-state and dwell counter: start only from IDLE, abort from anywhere
  // else, otherwise advance when the dwell counter runs out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    if (state_q == S_IDLE) begin
      // abort beats a simultaneous start; a lone abort here does nothing
      if (start && !abort) begin
        state_d = S_LOAD;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (cnt_q <= ONE_CNT) begin
      // "<= 1" rather than "== 1" so a corrupted zero count cannot wedge the FSM
      state_d = successor(state_q);
    end

    if (state_d != state_q) begin
      cnt_d = entry_count(state_d);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE_CNT;
    end
  end

  // Output decode from the next state, so the registered strobes line up with
  // the state they describe rather than trailing it by a cycle.
  always_comb begin
    load_en_d     = 1'b0;
    init_d        = 1'b0;
    pe_clr_d      = 1'b0;
    acc_capture_d = 1'b0;
    sub_rst_d     = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    load_en_d     = (state_d == S_LOAD);
    init_d        = (state_d == S_INIT);
    acc_capture_d = (state_d == S_CAPTURE);
    done_d        = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    // accumulators are cleared once, in the first load cycle of a job
    pe_clr_d      = (state_q == S_IDLE) && (state_d == S_LOAD);
    // an abort of a live job flushes the loader and PE array for one cycle
    sub_rst_d     = abort && (state_q != S_IDLE);
  end

  // State, counter and output registers; rst holds the sub-blocks in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      load_en_q     <= 1'b0;
      init_q        <= 1'b0;
      pe_clr_q      <= 1'b0;
      acc_capture_q <= 1'b0;
      sub_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      load_en_q     <= load_en_d;
      init_q        <= init_d;
      pe_clr_q      <= pe_clr_d;
      acc_capture_q <= acc_capture_d;
      sub_rst_q     <= sub_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign load_en     = load_en_q;
  assign init        = init_q;
  assign pe_clr      = pe_clr_q;
  assign acc_capture = acc_capture_q;
  assign sub_rst     = sub_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifndef SYNTHESIS
  // Strobe exclusivity: at most one phase strobe at a time, pe_clr only in
  // the first load cycle, done only while busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0({load_en_q, init_q, acc_capture_q, done_q}));
      assert (!pe_clr_q || load_en_q);
      assert (!done_q || busy_q);
    end
  end
`endif

endmodule
